fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
Read-side companion to the team's synchronous FIFO (registered dout, one-cycle read latency, rd_en ignored when empty). It drains the FIFO and presents the words as a valid/ready stream. A small output buffer absorbs the read latency so the stream sustains one word per cycle. It also frames the stream into fixed-length packets for the downstream spin-update / result path.

Parameters:
WIDTH, 8, data word width; must match the attached FIFO.
PKT_LEN, 16, beats per packet; m_last is asserted on the final beat; must be >= 1.
IDX_W, $clog2(PKT_LEN) (minimum 1), width of the beat index.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO read request
fifo_dout  in  WIDTH  FIFO registered read data, valid the cycle after an accepted read
m_valid  out  1  stream word available
m_ready  in  1  downstream accept
m_data  out  WIDTH  stream data
m_last  out  1  final beat of the current packet
m_beat_idx  out  IDX_W  position of the current beat within its packet (0..PKT_LEN-1)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. The FIFO and this block share rst.
- Outputs after reset: fifo_rd_en=0, m_valid=0, m_data=0, m_last=0 (or 1 if PKT_LEN=1), m_beat_idx=0. Buffer, in-flight flag and beat counter are cleared.
- Reset mid-operation: a read in flight is discarded, and buffered words are dropped.
- Read issue: fifo_rd_en = !fifo_empty && (buf_cnt + inflight) < 3.
  - fifo_rd_en must not depend combinationally on m_ready.
  - It is never asserted while fifo_empty=1.
- In-flight tracking: inflight <= fifo_rd_en each cycle. When inflight=1, fifo_dout is captured into the buffer tail in that cycle.
- Output buffer: 3-entry FIFO-ordered buffer with buf_cnt 0..3. A capture and a pop in the same cycle leave buf_cnt unchanged. Overflow is impossible by construction; the bench checks this with an assertion.
- Stream side:
  - m_valid = (buf_cnt != 0).
  - m_data is the buffer head.
  - The handshake completes when m_valid && m_ready.
  - While m_valid && !m_ready, m_data, m_last and m_beat_idx hold stable.
  - m_valid never drops without a handshake.
- Latency: first word written into an idle, empty FIFO appears on m_valid 3 cycles after the FIFO write edge:
  - FIFO write edge, then empty deasserts;
  - fifo_rd_en high;
  - dout registered;
  - captured into the buffer.
- Throughput: with m_ready held high and the FIFO non-empty, one handshake per cycle in steady state.
- Framing:
  - beat_cnt increments on each handshake and wraps from PKT_LEN-1 to 0.
  - m_beat_idx = beat_cnt.
  - m_last = (beat_cnt == PKT_LEN-1).
  - The counter only advances on a handshake; a stalled stream does not advance it.
- FIFO empty mid-packet: the stream simply stalls (m_valid=0). The packet position is kept and resumes with the next word.
- Backpressure: with m_ready=0, reads continue until buf_cnt + inflight = 3, then fifo_rd_en=0. No data is lost, and the FIFO fills naturally (its full flag throttles the writer).

Decomposition:
- Shared header/package: OBUF_DEPTH=3 and the read-latency constant (1), both shared with the FIFO owner.
- One natural sub-module: stream_obuf.
  - Contents: the 3-entry buffer, with push/pop/cnt and the head output.
  - Top level keeps: read issue, the inflight flag and the beat counter.

Test Plan:
- Reset then idle: rst high for 2 cycles, FIFO empty -> m_valid=0, fifo_rd_en=0, m_beat_idx=0 throughout.
- Single word: FIFO write 0xA5 into an empty FIFO, m_ready=1 -> m_valid high for exactly 1 cycle, 3 cycles after the write, with m_data=0xA5, m_beat_idx=0, m_last=0.
- Streaming with PKT_LEN=4: 12 words 0x00..0x0B, m_ready=1 -> 12 back-to-back handshakes, in order; m_last on 0x03, 0x07 and 0x0B.
- Backpressure: 8 words queued, m_ready=0 for 10 cycles then 1:
  - at most 3 reads are issued while stalled;
  - m_data holds 0x00 stable during the stall;
  - all 8 words arrive in order with no gaps.
- Random m_ready (50%) and random writes, 1000 words -> scoreboard: no loss, duplication or reorder; m_last every PKT_LEN beats; buf_cnt never exceeds 3.
- Reset mid-packet: assert rst after beat 2 with 1 read in flight -> next cycle m_valid=0, buf_cnt=0, m_beat_idx=0; the first post-reset word has m_beat_idx=0.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// Constants shared with the synchronous FIFO owner, plus small sizing and pointer helpers.
package fifo_stream_reader_pkg;

    localparam int OBUF_DEPTH = 3;
    localparam int RD_LATENCY = 1;

    localparam int OBUF_CNT_W = $clog2(OBUF_DEPTH + 1);
    localparam int OBUF_PTR_W = $clog2(OBUF_DEPTH);

    typedef logic [OBUF_CNT_W-1:0] obuf_cnt_t;
    typedef logic [OBUF_PTR_W-1:0] obuf_ptr_t;

    function automatic int idx_width(input int pkt_len);
        return (pkt_len > 1) ? $clog2(pkt_len) : 1;
    endfunction

    // The buffer depth is not a power of two, so pointers wrap explicitly.
    function automatic obuf_ptr_t ptr_inc(input obuf_ptr_t p);
        return (p == obuf_ptr_t'(OBUF_DEPTH - 1)) ? '0 : p + obuf_ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus the framed output stream; master is the reader, slave is the FIFO/consumer side.
interface fifo_stream_reader_if
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 16,
    parameter int IDX_W   = idx_width(PKT_LEN)
);
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_dout;

    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic [IDX_W-1:0] m_beat_idx;

    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last, m_beat_idx
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last, m_beat_idx
    );

endinterface

// File: rtl/fifo_stream_reader_stream_obuf.sv
// Three-entry in-order buffer absorbing the FIFO read latency; a push is visible at head next cycle.
// Full without a same-cycle pop refuses the push; the caller's issue limit keeps that from happening.
module fifo_stream_reader_stream_obuf
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output obuf_cnt_t        cnt
);

    logic [WIDTH-1:0] mem [OBUF_DEPTH];
    obuf_ptr_t        wr_ptr;
    obuf_ptr_t        rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && (cnt != '0);
    assign push_ok = push && ((cnt != obuf_cnt_t'(OBUF_DEPTH)) || pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + obuf_cnt_t'(1);
                2'b01:   cnt <= cnt - obuf_cnt_t'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO into a valid/ready stream framed into PKT_LEN-beat packets; 3 cycles write to m_valid.
// While m_ready is low the head beat holds and reads stop once buffered plus in-flight words fill the buffer.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 16,
    parameter int IDX_W   = idx_width(PKT_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_stream_reader_if.master bus
);

    obuf_cnt_t             buf_cnt;
    logic [WIDTH-1:0]      buf_head;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic                  inflight;
    logic                  rd_en;
    logic                  valid;
    logic                  hs;
    logic                  last_beat;
    logic [IDX_W-1:0]      beat_cnt;

    // Issue only against space already committed, so m_ready never reaches fifo_rd_en.
    always_comb begin
        rd_en = 1'b0;
        if (!bus.fifo_empty && ((int'(buf_cnt) + $countones(rd_pipe)) < OBUF_DEPTH)) begin
            rd_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= RD_LATENCY'({rd_pipe, rd_en});
        end
    end

    assign inflight = rd_pipe[RD_LATENCY-1];

    fifo_stream_reader_stream_obuf #(
        .WIDTH (WIDTH)
    ) u_obuf (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_dat (bus.fifo_dout),
        .pop      (hs),
        .head     (buf_head),
        .cnt      (buf_cnt)
    );

    assign valid     = (buf_cnt != '0);
    assign hs        = valid && bus.m_ready;
    assign last_beat = (beat_cnt == IDX_W'(PKT_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (hs) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + IDX_W'(1);
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = valid;
    assign bus.m_data     = buf_head;
    assign bus.m_last     = last_beat;
    assign bus.m_beat_idx = beat_cnt;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-backed FIFO model, handshake scoreboard, vector table and random traffic.
module tb_fifo_stream_reader;
    import fifo_stream_reader_pkg::*;

    localparam int WIDTH   = 8;
    localparam int PKT_LEN = 4;
    localparam int IDX_W   = idx_width(PKT_LEN);
    localparam int FDEPTH  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) bus ();

    fifo_stream_reader #(
        .WIDTH   (WIDTH),
        .PKT_LEN (PKT_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int reads = 0;

    logic             wr_en  = 1'b0;
    logic [WIDTH-1:0] wr_dat = '0;
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] exp_q[$];

    typedef struct {
        logic [WIDTH-1:0] dat;
        logic             last;
        logic [IDX_W-1:0] idx;
        int               cyc;
    } hs_t;
    hs_t hs_q[$];

    typedef struct {
        logic             wr;
        logic [WIDTH-1:0] wd;
        logic             rdy;
        logic             e_vld;
        logic             e_rd;
        logic [WIDTH-1:0] e_dat;
        logic             e_last;
        logic [IDX_W-1:0] e_idx;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic rs);
        @(posedge clk);
        #1;
        wr_en       = w;
        wr_dat      = d;
        bus.m_ready = r;
        rst         = rs;
    endtask

    // Synchronous FIFO: registered dout, reads ignored when empty, shares rst with the DUT.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            fq.delete();
            exp_q.delete();
            bus.fifo_dout  <= '0;
            bus.fifo_empty <= 1'b1;
        end else begin
            if (bus.fifo_rd_en && fq.size() > 0) begin
                bus.fifo_dout <= fq.pop_front();
            end
            if (wr_en && fq.size() < FDEPTH) begin
                fq.push_back(wr_dat);
                exp_q.push_back(wr_dat);
            end
            bus.fifo_empty <= (fq.size() == 0);
        end
    end

    int               exp_idx = 0;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_dat = '0;
    logic             prev_last = 1'b0;
    logic [IDX_W-1:0] prev_idx = '0;
    logic [WIDTH-1:0] sb_e;
    hs_t              hrec;

    always @(negedge clk) begin
        if (rst) begin
            exp_idx    = 0;
            prev_stall = 1'b0;
        end else begin
            if (bus.fifo_rd_en) begin
                reads++;
                check("rd_while_empty", int'(bus.fifo_empty), 0);
            end
            if (prev_stall) begin
                check("stall_vld",  int'(bus.m_valid), 1);
                check("stall_dat",  int'(bus.m_data), int'(prev_dat));
                check("stall_last", int'(bus.m_last), int'(prev_last));
                check("stall_idx",  int'(bus.m_beat_idx), int'(prev_idx));
            end
            if (dut.u_obuf.push) begin
                total++;
                assert (int'(dut.u_obuf.cnt) < OBUF_DEPTH || dut.u_obuf.pop) else begin
                    bad++;
                    $display("FAIL obuf_overflow: cnt=%0d with push and no pop, required < %0d",
                             dut.u_obuf.cnt, OBUF_DEPTH);
                end
            end
            if (bus.m_valid && bus.m_ready) begin
                hrec.dat  = bus.m_data;
                hrec.last = bus.m_last;
                hrec.idx  = bus.m_beat_idx;
                hrec.cyc  = cyc;
                hs_q.push_back(hrec);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra: got word %0h, required no word outstanding", bus.m_data);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_data", int'(bus.m_data), int'(sb_e));
                end
                check("sb_idx",  int'(bus.m_beat_idx), exp_idx);
                check("sb_last", int'(bus.m_last), int'(exp_idx == PKT_LEN - 1));
                exp_idx = (exp_idx + 1) % PKT_LEN;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_dat   = bus.m_data;
            prev_last  = bus.m_last;
            prev_idx   = bus.m_beat_idx;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int   w0;
        int   n_wr;
        logic w;

        // One word into an idle FIFO: write in row 0, visible in row 3, accepted at once.
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, IDX_W'(0)};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, IDX_W'(0)};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, IDX_W'(0)};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, IDX_W'(0)};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, IDX_W'(1)};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, IDX_W'(1)};

        rst = 1'b1; wr_en = 1'b0; wr_dat = '0; bus.m_ready = 1'b0;

        step(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk); #1;
        check("rst_vld",  int'(bus.m_valid), 0);
        check("rst_rd",   int'(bus.fifo_rd_en), 0);
        check("rst_idx",  int'(bus.m_beat_idx), 0);
        check("rst_dat",  int'(bus.m_data), 0);
        check("rst_last", int'(bus.m_last), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            @(negedge clk); #1;
            check("idle_vld", int'(bus.m_valid), 0);
            check("idle_rd",  int'(bus.fifo_rd_en), 0);
            check("idle_idx", int'(bus.m_beat_idx), 0);
        end

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].wr, tbl[i].wd, tbl[i].rdy, 1'b0);
            @(negedge clk); #1;
            check($sformatf("vec%0d_vld", i),  int'(bus.m_valid), int'(tbl[i].e_vld));
            check($sformatf("vec%0d_rd", i),   int'(bus.fifo_rd_en), int'(tbl[i].e_rd));
            check($sformatf("vec%0d_last", i), int'(bus.m_last), int'(tbl[i].e_last));
            check($sformatf("vec%0d_idx", i),  int'(bus.m_beat_idx), int'(tbl[i].e_idx));
            if (tbl[i].e_vld) begin
                check($sformatf("vec%0d_dat", i), int'(bus.m_data), int'(tbl[i].e_dat));
            end
        end

        // Back-to-back streaming of 12 words.
        step(1'b0, '0, 1'b1, 1'b1);
        hs_q.delete();
        step(1'b1, 8'h00, 1'b1, 1'b0);
        w0 = cyc;
        for (int i = 1; i < 12; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 30 && hs_q.size() < 12; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("stream_cnt", hs_q.size(), 12);
        for (int i = 0; i < 12 && i < hs_q.size(); i++) begin
            check($sformatf("stream%0d_dat", i),  int'(hs_q[i].dat), i);
            check($sformatf("stream%0d_last", i), int'(hs_q[i].last), int'(i % PKT_LEN == PKT_LEN - 1));
            check($sformatf("stream%0d_idx", i),  int'(hs_q[i].idx), i % PKT_LEN);
            check($sformatf("stream%0d_cyc", i),  hs_q[i].cyc, w0 + 3 + i);
        end

        // Backpressure: 8 words queued while the consumer stalls for 10 cycles.
        step(1'b0, '0, 1'b0, 1'b1);
        hs_q.delete();
        reads = 0;
        for (int i = 0; i < 10; i++) step(i < 8, 8'(i), 1'b0, 1'b0);
        @(negedge clk); #1;
        check("bp_reads", reads, 3);
        check("bp_vld",   int'(bus.m_valid), 1);
        check("bp_dat",   int'(bus.m_data), 0);
        check("bp_no_hs", hs_q.size(), 0);
        step(1'b0, '0, 1'b1, 1'b0);
        w0 = cyc;
        for (int i = 0; i < 40 && hs_q.size() < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("bp_cnt", hs_q.size(), 8);
        for (int i = 0; i < 8 && i < hs_q.size(); i++) begin
            check($sformatf("bp%0d_dat", i), int'(hs_q[i].dat), i);
            check($sformatf("bp%0d_cyc", i), hs_q[i].cyc, w0 + i);
        end

        // Reset after beat 2 while a read is in flight.
        step(1'b0, '0, 1'b1, 1'b1);
        hs_q.delete();
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
        @(negedge clk); #1;
        check("mid_beats", hs_q.size(), 3);
        step(1'b0, '0, 1'b1, 1'b1);
        @(negedge clk); #1;
        check("mid_inflight", int'(dut.inflight), 1);
        step(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk); #1;
        check("mid_vld",      int'(bus.m_valid), 0);
        check("mid_cnt",      int'(dut.u_obuf.cnt), 0);
        check("mid_idx",      int'(bus.m_beat_idx), 0);
        check("mid_inflight0", int'(dut.inflight), 0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        for (int i = 0; i < 10 && hs_q.size() < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("mid_post_cnt", hs_q.size(), 4);
        if (hs_q.size() >= 4) begin
            check("mid_post_dat", int'(hs_q[3].dat), 8'h77);
            check("mid_post_idx", int'(hs_q[3].idx), 0);
        end

        // Random writes and 50% m_ready, 1000 words through the scoreboard.
        hs_q.delete();
        n_wr = 0;
        for (int c = 0; c < 20000 && (n_wr < 1000 || exp_q.size() != 0); c++) begin
            w = (n_wr < 1000) && (fq.size() < FDEPTH - 1) && ($urandom_range(1, 0) == 1);
            step(w, 8'($urandom), 1'($urandom_range(1, 0)), 1'b0);
            if (w) n_wr++;
        end
        check("rand_written", n_wr, 1000);
        check("rand_hs",      hs_q.size(), 1000);
        check("rand_left",    exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
